// File: rtl/pwm_bank.sv
// Multi-channel PWM bank: one shared up-counter with a programmable period, per-channel
// duty compare, and double-buffered duty/period updates applied only at the period wrap.
module pwm_bank #(
  parameter int unsigned CHANNELS = 8,
  parameter int unsigned WIDTH    = 16,
  parameter bit          INVERT   = 1'b1
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      enable,
  input  logic                      load,
  input  logic [WIDTH-1:0]          period,
  input  logic [CHANNELS*WIDTH-1:0] duty,
  output logic [CHANNELS-1:0]       pwm_o,
  output logic                      cycle_start,
  output logic                      pending
);

  logic [WIDTH-1:0]          count_p0;
  logic [WIDTH-1:0]          period_act;
  logic [WIDTH-1:0]          period_shd;
  logic [CHANNELS*WIDTH-1:0] duty_act;
  logic [CHANNELS*WIDTH-1:0] duty_shd;
  logic [CHANNELS-1:0]       raw_p0;
  logic                      wrap_p0;

  function automatic logic duty_on(input logic [WIDTH-1:0] d, input logic [WIDTH-1:0] c);
    return d > c;
  endfunction

  assign wrap_p0 = enable && (count_p0 == period_act);

  always_comb begin
    raw_p0 = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      raw_p0[i] = enable && duty_on(duty_act[i*WIDTH +: WIDTH], count_p0);
    end
  end

  // p0 -> p1: counter, shadow/active update, registered outputs
  always_ff @(posedge clock) begin
    if (reset) begin
      count_p0    <= '0;
      period_act  <= '1;
      period_shd  <= '1;
      duty_act    <= '0;
      duty_shd    <= '0;
      pending     <= 1'b0;
      pwm_o       <= {CHANNELS{INVERT}};
      cycle_start <= 1'b0;
    end else begin
      count_p0    <= (!enable || wrap_p0) ? '0 : count_p0 + 1'b1;
      pwm_o       <= raw_p0 ^ {CHANNELS{INVERT}};
      cycle_start <= enable && (count_p0 == '0);

      if (load) begin
        period_shd <= period;
        duty_shd   <= duty;
      end

      // A load on the wrap bypasses the shadow so it governs the very next period.
      if (wrap_p0) begin
        pending <= 1'b0;
        if (load) begin
          period_act <= period;
          duty_act   <= duty;
        end else if (pending) begin
          period_act <= period_shd;
          duty_act   <= duty_shd;
        end
      end else if (load) begin
        pending <= 1'b1;
      end else if (!enable && pending) begin
        period_act <= period_shd;
        duty_act   <= duty_shd;
        pending    <= 1'b0;
      end
    end
  end

endmodule

// File: doc/pwm_bank.md
Name: pwm_bank

Overview:
Parametrised multi-channel PWM generator. It replaces the fixed 8x16-bit free-running PWM block. All channels share one up-counter with a programmable period. Duty and period updates are double-buffered and applied only at the period boundary, which makes updates glitch-free. Per-build output polarity, a global enable and a cycle-start strobe support the LED/motor drive paths on the board.

Parameters:
CHANNELS, 8, number of PWM outputs (1..32)
WIDTH, 16, counter, duty and period width in bits (2..24)
INVERT, 1, 1 = outputs active-low (driven low while "on"); 0 = active-high

Ports:
clock  input  1  system clock; all logic on rising edge
reset  input  1  synchronous, active-high reset
enable  input  1  1 = run counter and outputs; 0 = hold counter at 0, outputs inactive
load  input  1  single-cycle strobe: capture duty and period into shadow registers
period  input  WIDTH  counter top value; cycle length = period+1 clocks
duty  input  CHANNELS*WIDTH  packed duty values, channel i at bits [i*WIDTH +: WIDTH]
pwm_o  output  CHANNELS  PWM outputs, polarity per INVERT
cycle_start  output  1  one-clock pulse aligned with the first output cycle of each PWM period
pending  output  1  1 = shadow values captured but not yet applied

Behaviour:
- Reset (synchronous, priority over everything):
  - count=0; active and shadow duty all 0; active and shadow period = all ones (2^WIDTH-1); pending=0; cycle_start=0.
  - pwm_o inactive: all ones if INVERT=1, all zeros if INVERT=0.
- Counter when enable=1:
  - count increments by 1 per clock.
  - When count==period_active, next count=0 (the "wrap"). No WIDTH overflow is possible.
  - period_active=0 gives count stuck at 0 with a wrap every clock.
- Compare:
  - raw[i] = (duty_active[i] > count), unsigned.
  - pwm_o[i] is registered: pwm_o(t+1) = raw(t) XOR INVERT. Latency is 1 clock from count to pin.
  - duty=0 gives 0% on-time. duty >= period_active+1 gives 100% on-time with no glitch at the wrap.
- Shadow load:
  - When load=1, shadow_duty<=duty, shadow_period<=period, pending<=1.
  - A repeated load before the wrap overwrites the shadow; only the last captured values apply.
- Apply:
  - On a wrap cycle with enable=1: if pending, active<=shadow and pending<=0.
  - Load coinciding with a wrap: the inputs present on that cycle go directly to active (bypassing the shadow) and pending stays 0.
  - The new values govern the period beginning at count=0.
- Disable (enable=0):
  - count forced to 0; raw forced 0, so pwm_o goes inactive one clock later.
  - Loads are still accepted. Any pending shadow is applied every cycle, so pending clears the cycle after a load.
- Enable rise:
  - The first enabled cycle has count=0 and starts a full period with the current active values.
- cycle_start:
  - Registered. It is 1 in the cycle whose pwm_o reflects count=0, i.e. one clock after count==0.
  - It fires on every wrap and on the first period after an enable rise.
  - It is 0 while enable=0 and in reset.
- Reset mid-period: takes effect next clock regardless of load, enable or pending state. All outputs are at their reset values one clock after reset is sampled.
- No combinational path from any input to any output.

Test Plan:
- Bench configuration for all scenarios: CHANNELS=4, WIDTH=8, INVERT=0.
- Reset, then enable=1 with no load: pwm_o==0 continuously; cycle_start pulses every 256 clocks; pending==0.
- Load period=9 and duty={0,3,10,255} (ch0..3), then run 3 periods:
  - After the first wrap, the period is 10 clocks.
  - ch0 is always 0; ch1 is high 3 of 10; ch2 and ch3 are high 10 of 10 with no low glitch at the wrap.
  - cycle_start spacing is 10.
- Mid-period update: during a period=9 run, at count=4 load duty ch1=7:
  - pending=1 until the wrap.
  - ch1 stays at 3/10 for the current period, then 7/10.
  - Two loads in the same period: only the second value appears.
- Load exactly on the wrap cycle (count==9) with duty ch1=5: the next period shows ch1 high 5 clocks and pending never asserts.
- enable=0 mid-period:
  - pwm_o==0 one clock later and count holds at 0.
  - A load while disabled clears pending the next cycle.
  - Re-enable gives cycle_start one clock after the first count=0 cycle, and the new duty applies immediately.
- Rebuild with INVERT=1 and assert reset at count=5:
  - pwm_o==4'b1111 one clock later; cycle_start=0; active period=255, duty=0.
  - A period=3, duty ch0=2 load followed by enable shows ch0 low 2 of 4 clocks.
